// File: rtl/alu_sweep_ctrl.sv
// alu_sweep_ctrl: latches one operand pair, steps the ALU opcode select through
// every opcode and offers each registered (sel, Y, Cout) result on valid/ready.
// Optional feature macro: ALU_SWEEP_ZERO_FLAG_EN adds the registered res_zero output.
module alu_sweep_ctrl #(
  parameter int WIDTH   = 8,
  parameter int SEL_W   = 3,
  parameter int NUM_OPS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [SEL_W-1:0] res_sel,
  output logic [WIDTH-1:0] res_y,
  output logic             res_cout,
`ifdef ALU_SWEEP_ZERO_FLAG_EN
  output logic             res_zero,
`endif
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    HOLD   = 2'd2,
    FINISH = 2'd3
  } state_e;

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_OPS - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [SEL_W-1:0] alu_sel_q, alu_sel_d;
  logic             res_valid_q, res_valid_d;
  logic [SEL_W-1:0] res_sel_q, res_sel_d;
  logic [WIDTH-1:0] res_y_q, res_y_d;
  logic             res_cout_q, res_cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef ALU_SWEEP_ZERO_FLAG_EN
  logic             res_zero_q, res_zero_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SETUP;
      SETUP:   state_d = HOLD;
      HOLD:    if (res_ready) state_d = (alu_sel_q == LAST_SEL) ? FINISH : SETUP;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Everything visible is computed here and registered below, so no input
  // reaches an output combinationally.
  always_comb begin
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    res_valid_d = res_valid_q;
    res_sel_d   = res_sel_q;
    res_y_d     = res_y_q;
    res_cout_d  = res_cout_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
`ifdef ALU_SWEEP_ZERO_FLAG_EN
    res_zero_d  = res_zero_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          alu_a_d   = a_in;
          alu_b_d   = b_in;
          alu_sel_d = '0;
          busy_d    = 1'b1;
        end
      end
      SETUP: begin
        res_y_d     = alu_y;
        res_cout_d  = alu_cout;
        res_sel_d   = alu_sel_q;
        res_valid_d = 1'b1;
`ifdef ALU_SWEEP_ZERO_FLAG_EN
        res_zero_d  = (alu_y == '0);
`endif
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (alu_sel_q == LAST_SEL) begin
            done_d = 1'b1;
          end else begin
            alu_sel_d = alu_sel_q + 1'b1;
          end
        end
      end
      FINISH: begin
        busy_d = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      res_valid_q <= 1'b0;
      res_sel_q   <= '0;
      res_y_q     <= '0;
      res_cout_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef ALU_SWEEP_ZERO_FLAG_EN
      res_zero_q  <= 1'b0;
`endif
    end else begin
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      res_valid_q <= res_valid_d;
      res_sel_q   <= res_sel_d;
      res_y_q     <= res_y_d;
      res_cout_q  <= res_cout_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef ALU_SWEEP_ZERO_FLAG_EN
      res_zero_q  <= res_zero_d;
`endif
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign res_valid = res_valid_q;
  assign res_sel   = res_sel_q;
  assign res_y     = res_y_q;
  assign res_cout  = res_cout_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef ALU_SWEEP_ZERO_FLAG_EN
  assign res_zero  = res_zero_q;
`endif

endmodule

// File: tb/tb_alu_sweep_ctrl.sv
// Self-checking bench for alu_sweep_ctrl: bench ALU Y=(A+B+sel) mod 256, results
// compared against sums computed from the latched operands.
module tb_alu_sweep_ctrl;

  localparam int NOPS = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a_in = '0;
  logic [7:0] b_in = '0;
  logic       busy;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_sel;
  logic [7:0] alu_y;
  logic       alu_cout;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [2:0] res_sel;
  logic [7:0] res_y;
  logic       res_cout;
  logic       done;
`ifdef ALU_SWEEP_ZERO_FLAG_EN
  logic       res_zero;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] y;
    logic       cout;
  } res_t;

  res_t got_q[$];
  int   done_cnt = 0;

  alu_sweep_ctrl #(.WIDTH(8), .SEL_W(3), .NUM_OPS(NOPS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_y(alu_y), .alu_cout(alu_cout), .res_valid(res_valid),
    .res_ready(res_ready), .res_sel(res_sel), .res_y(res_y),
    .res_cout(res_cout),
`ifdef ALU_SWEEP_ZERO_FLAG_EN
    .res_zero(res_zero),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  // Bench ALU: combinational sum of operands and opcode
  logic [8:0] alu_sum;
  assign alu_sum  = {1'b0, alu_a} + {1'b0, alu_b} + {6'd0, alu_sel};
  assign alu_y    = alu_sum[7:0];
  assign alu_cout = alu_sum[8];

  // Monitor: records every handshake that the next rising edge will complete
  always @(negedge clk) begin
    if (rst_n) begin
      if (res_valid && res_ready) got_q.push_back('{sel: res_sel, y: res_y, cout: res_cout});
      if (done) done_cnt++;
    end
  end

  task automatic start_sweep(input logic [7:0] a, input logic [7:0] b);
    @(posedge clk); #1;
    a_in = a; b_in = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input bit rand_ready, output bit timed_out);
    int n;
    n = 0;
    timed_out = 1'b0;
    while (done_cnt == 0 && n < 200) begin
      @(posedge clk); #1;
      if (rand_ready) begin
        res_ready = 1'($urandom % 2);
        a_in = 8'($urandom);
        b_in = 8'($urandom);
      end
      n++;
    end
    if (done_cnt == 0) timed_out = 1'b1;
    res_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({busy, done, res_valid, res_cout, alu_a, alu_b, alu_sel, res_sel, res_y} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: busy=%b done=%b valid=%b a=%h b=%h sel=%0d res_y=%h, required all zero",
               busy, done, res_valid, alu_a, alu_b, alu_sel, res_y);
    end
`ifdef ALU_SWEEP_ZERO_FLAG_EN
    checks++;
    if (res_zero !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_zero: got %b required 0", res_zero);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_sweep;
    int sum;
    logic exp_valid, exp_done, exp_busy;
    got_q.delete(); done_cnt = 0;
    res_ready = 1'b1;
    start_sweep(8'hAA, 8'hCC);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_busy_after_start: got %b required 1", busy);
    end
    for (int n = 1; n <= 18; n++) begin
      @(posedge clk); #1;
      exp_valid = (n % 2 == 1) && (n <= 2 * NOPS - 1);
      exp_done  = (n == 2 * NOPS);
      exp_busy  = (n <= 2 * NOPS);
      checks++;
      if (res_valid !== exp_valid || done !== exp_done || busy !== exp_busy) begin
        errors++;
        $display("[TB] FAIL basic_timing edge %0d: valid=%b done=%b busy=%b, required %b %b %b",
                 n, res_valid, done, busy, exp_valid, exp_done, exp_busy);
      end
      if (exp_valid) begin
        sum = 8'hAA + 8'hCC + (n - 1) / 2;
        checks++;
        if (res_sel !== 3'((n - 1) / 2) || res_y !== 8'(sum) || res_cout !== (sum > 255)) begin
          errors++;
          $display("[TB] FAIL basic_result edge %0d: sel=%0d y=%h cout=%b, required %0d %h %b",
                   n, res_sel, res_y, res_cout, (n - 1) / 2, 8'(sum), sum > 255);
        end
      end
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("[TB] FAIL basic_done_count: got %0d required 1", done_cnt);
    end
  endtask

  task automatic test_back_pressure;
    bit stalled, to;
    int sum;
    got_q.delete(); done_cnt = 0;
    res_ready = 1'b1;
    stalled = 1'b0;
    start_sweep(8'hAA, 8'hCC);
    for (int n = 0; n < 40 && !stalled; n++) begin
      @(posedge clk); #1;
      if (res_valid && res_sel == 3'd3) begin
        res_ready = 1'b0;
        stalled = 1'b1;
      end
    end
    checks++;
    if (!stalled) begin
      errors++;
      $display("[TB] FAIL bp_reach_sel3: result sel=3 never offered, required within 40 cycles");
    end
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      checks++;
      if (res_valid !== 1'b1 || res_sel !== 3'd3 || res_y !== 8'h79 || alu_sel !== 3'd3) begin
        errors++;
        $display("[TB] FAIL bp_stall cycle %0d: valid=%b sel=%0d y=%h alu_sel=%0d, required 1 3 79 3",
                 n, res_valid, res_sel, res_y, alu_sel);
      end
    end
    res_ready = 1'b1;
    wait_done(1'b0, to);
    checks++;
    if (to || done_cnt != 1 || got_q.size() != NOPS) begin
      errors++;
      $display("[TB] FAIL bp_completion: timeout=%b done=%0d results=%0d, required 0 1 %0d",
               to, done_cnt, got_q.size(), NOPS);
    end
    for (int k = 0; k < got_q.size(); k++) begin
      sum = 8'hAA + 8'hCC + k;
      checks++;
      if (got_q[k].sel !== 3'(k) || got_q[k].y !== 8'(sum) || got_q[k].cout !== (sum > 255)) begin
        errors++;
        $display("[TB] FAIL bp_result %0d: sel=%0d y=%h cout=%b, required %0d %h %b",
                 k, got_q[k].sel, got_q[k].y, got_q[k].cout, k, 8'(sum), sum > 255);
      end
    end
  endtask

  task automatic test_start_while_busy;
    bit pulsed, to;
    int sum;
    got_q.delete(); done_cnt = 0;
    res_ready = 1'b1;
    pulsed = 1'b0;
    start_sweep(8'hAA, 8'hCC);
    for (int n = 0; n < 40 && !pulsed; n++) begin
      @(posedge clk); #1;
      if (alu_sel == 3'd2) begin
        a_in = 8'h00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        pulsed = 1'b1;
      end
    end
    wait_done(1'b0, to);
    checks++;
    if (to || done_cnt != 1 || got_q.size() != NOPS || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_start_completion: timeout=%b done=%0d results=%0d busy=%b, required 0 1 %0d 0",
               to, done_cnt, got_q.size(), NOPS, busy);
    end
    for (int k = 0; k < got_q.size(); k++) begin
      sum = 8'hAA + 8'hCC + k;
      checks++;
      if (got_q[k].sel !== 3'(k) || got_q[k].y !== 8'(sum) || got_q[k].cout !== (sum > 255)) begin
        errors++;
        $display("[TB] FAIL busy_start_result %0d: sel=%0d y=%h cout=%b, required %0d %h %b",
                 k, got_q[k].sel, got_q[k].y, got_q[k].cout, k, 8'(sum), sum > 255);
      end
    end
  endtask

  task automatic test_reset_mid_sweep;
    bit held, to;
    int sum;
    got_q.delete(); done_cnt = 0;
    res_ready = 1'b1;
    held = 1'b0;
    start_sweep(8'hAA, 8'hCC);
    for (int n = 0; n < 40 && !held; n++) begin
      @(posedge clk); #1;
      if (res_valid && res_sel == 3'd5) begin
        res_ready = 1'b0;
        held = 1'b1;
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, res_valid, res_cout, alu_a, alu_b, alu_sel, res_sel, res_y} !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: busy=%b valid=%b a=%h b=%h sel=%0d res_sel=%0d y=%h, required all zero",
               busy, res_valid, alu_a, alu_b, alu_sel, res_sel, res_y);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    res_ready = 1'b1;
    got_q.delete(); done_cnt = 0;
    start_sweep(8'h01, 8'h02);
    wait_done(1'b0, to);
    checks++;
    if (to || got_q.size() != NOPS) begin
      errors++;
      $display("[TB] FAIL midreset_restart: timeout=%b results=%0d, required 0 %0d", to, got_q.size(), NOPS);
    end
    for (int k = 0; k < got_q.size(); k++) begin
      sum = 1 + 2 + k;
      checks++;
      if (got_q[k].sel !== 3'(k) || got_q[k].y !== 8'(sum) || got_q[k].cout !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midreset_result %0d: sel=%0d y=%h cout=%b, required %0d %h 0",
                 k, got_q[k].sel, got_q[k].y, got_q[k].cout, k, 8'(sum));
      end
    end
  endtask

  task automatic test_zero_flag;
    int sum;
    got_q.delete(); done_cnt = 0;
    res_ready = 1'b1;
    start_sweep(8'hFF, 8'h01);
    for (int n = 1; n <= 4; n++) begin
      @(posedge clk); #1;
      if (n % 2 == 1) begin
        sum = 8'hFF + 8'h01 + (n - 1) / 2;
        checks++;
        if (res_valid !== 1'b1 || res_y !== 8'(sum) || res_cout !== (sum > 255)) begin
          errors++;
          $display("[TB] FAIL zero_result edge %0d: valid=%b y=%h cout=%b, required 1 %h %b",
                   n, res_valid, res_y, res_cout, 8'(sum), sum > 255);
        end
`ifdef ALU_SWEEP_ZERO_FLAG_EN
        checks++;
        if (res_zero !== (8'(sum) == 8'h00)) begin
          errors++;
          $display("[TB] FAIL zero_flag edge %0d: got %b required %b", n, res_zero, 8'(sum) == 8'h00);
        end
`endif
      end
    end
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic test_random_sweeps;
    bit to;
    int sum;
    logic [7:0] a, b;
    for (int r = 0; r < 4; r++) begin
      got_q.delete(); done_cnt = 0;
      a = 8'($urandom);
      b = 8'($urandom);
      res_ready = 1'($urandom % 2);
      start_sweep(a, b);
      wait_done(1'b1, to);
      checks++;
      if (to || done_cnt != 1 || got_q.size() != NOPS) begin
        errors++;
        $display("[TB] FAIL rand_completion run %0d: timeout=%b done=%0d results=%0d, required 0 1 %0d",
                 r, to, done_cnt, got_q.size(), NOPS);
      end
      for (int k = 0; k < got_q.size(); k++) begin
        sum = int'(a) + int'(b) + k;
        checks++;
        if (got_q[k].sel !== 3'(k) || got_q[k].y !== 8'(sum) || got_q[k].cout !== (sum > 255)) begin
          errors++;
          $display("[TB] FAIL rand_result run %0d idx %0d: sel=%0d y=%h cout=%b, required %0d %h %b",
                   r, k, got_q[k].sel, got_q[k].y, got_q[k].cout, k, 8'(sum), sum > 255);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_sweep();
    test_back_pressure();
    test_start_while_busy();
    test_reset_mid_sweep();
    test_zero_flag();
    test_random_sweeps();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_sweep_ctrl.md
Name: alu_sweep_ctrl

Overview:
Sequencer that sits directly upstream of the 8-bit ALU and also consumes its outputs.
- On start, latches one operand pair, drives it on the ALU's A/B inputs and steps sel through every opcode.
- Registers each (sel, Y, Cout) result and offers it downstream on a valid/ready handshake.
- Replaces the ad-hoc delay-loop sweep with a synthesizable, back-pressurable controller.

Parameters:
WIDTH, 8, operand/result width (matches ALU A, B, Y)
SEL_W, 3, opcode select width
NUM_OPS, 8, opcodes swept per run (0 .. NUM_OPS-1); must be <= 2**SEL_W

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a sweep; sampled only in IDLE
a_in  input  WIDTH  operand A, latched on accepted start
b_in  input  WIDTH  operand B, latched on accepted start
busy  output  1  high from the cycle after accepted start through the FINISH cycle
alu_a  output  WIDTH  to ALU A
alu_b  output  WIDTH  to ALU B
alu_sel  output  SEL_W  to ALU sel
alu_y  input  WIDTH  from ALU Y (combinational)
alu_cout  input  1  from ALU Cout
res_valid  output  1  captured result available
res_ready  input  1  downstream accepts result
res_sel  output  SEL_W  opcode of captured result
res_y  output  WIDTH  captured Y
res_cout  output  1  captured Cout
done  output  1  one-cycle pulse after the last result is accepted

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs (alu_a, alu_b, alu_sel, res_*, busy, done) = 0. Reset mid-sweep aborts immediately; no partial result survives.
- Clocking: all outputs are registered; no combinational path from any input to any output.
- IDLE: busy=0. If start=1 at an edge: alu_a<=a_in, alu_b<=b_in, alu_sel<=0, go SETUP. Otherwise alu_a/alu_b/alu_sel hold their last values.
- SETUP (exactly 1 cycle): ALU inputs are stable. At the end edge: res_y<=alu_y, res_cout<=alu_cout, res_sel<=alu_sel, res_valid<=1, go HOLD.
- HOLD: res_valid=1; res_* and alu_* held stable.
  - res_ready=0: stay in HOLD.
  - res_ready=1 at an edge: res_valid<=0.
    - If alu_sel==NUM_OPS-1: go FINISH.
    - Else: alu_sel<=alu_sel+1, go SETUP.
- FINISH (1 cycle): done=1, busy=1. Next edge: done<=0, busy<=0, go IDLE.
- start while busy: ignored, not queued. start in FINISH: ignored. start is sampled again only in IDLE.
- Throughput: 2 cycles per opcode with res_ready tied high. With start sampled at edge E0, result k is valid after edge E(2k+1), and done is high in the cycle after edge E16 (NUM_OPS=8).
- res_valid never drops without a handshake. res_* never changes while res_valid=1.
- alu_sel increments without wrap; the terminal compare uses NUM_OPS-1.
- Operands a_in/b_in may change freely after the accepted start without affecting the sweep.

Optional Feature:
ALU_SWEEP_ZERO_FLAG_EN
- Defined: adds output res_zero (1 bit).
  - Registered with res_y at the SETUP capture edge; =1 iff alu_y==0.
  - Reset value 0; held during HOLD.
- Undefined: port res_zero and its register are absent; all other behaviour is identical.

Test Plan:
All scenarios use a bench ALU model: Y = (A+B+sel) mod 256, Cout = carry out of that sum.
- Basic sweep: reset, start with a_in=0xAA, b_in=0xCC, res_ready=1 -> eight results, sel 0..7.
  - Y = 0x76..0x7D, Cout=1 each.
  - res_valid high on odd cycles after start.
  - done pulses exactly once, 16 edges after start; busy falls with it.
- Back-pressure: same operands, res_ready=0 for 5 cycles at sel=3 -> res_valid stays 1; res_sel=3, res_y=0x79 stable; alu_sel stays 3; resumes on ready.
- Start while busy: pulse start with a_in=0x00 during sel=2 -> ignored; remaining results still use 0xAA/0xCC; exactly one done.
- Reset mid-sweep: assert rst_n=0 during HOLD at sel=5 -> all outputs 0 asynchronously (before next clk edge).
  - After release, start with a_in=0x01, b_in=0x02 -> sel 0 result Y=0x03, Cout=0.
- Zero flag (ALU_SWEEP_ZERO_FLAG_EN defined): a_in=0xFF, b_in=0x01 -> sel 0: Y=0x00, Cout=1, res_zero=1; sel 1: Y=0x01, res_zero=0.
